// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS EX front end: ALU opcodes, forward-select
// codes, the ID/EX register layout and the shift-op decode.
package mips_pkg;

    localparam int DATA_W = 32;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_SLL = 4'b0100;
    localparam logic [3:0] ALU_SRL = 4'b0101;
    localparam logic [3:0] ALU_SRA = 4'b0110;
    localparam logic [3:0] ALU_XOR = 4'b0111;
    localparam logic [3:0] ALU_SLT = 4'b1000;

    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    typedef struct packed {
        logic              valid;
        logic [4:0]        rs;
        logic [4:0]        rt;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic [DATA_W-1:0] imm;
        logic [4:0]        shamt;
        logic [3:0]        alu_op;
        logic              alu_src;
        logic [4:0]        write_reg;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              mem_to_reg;
    } ex_reg_t;

    localparam ex_reg_t EX_BUBBLE = '0;

    // Shifts take their data operand from rt rather than rs.
    function automatic logic is_shift_op(input logic [3:0] op);
        logic res;
        case (op)
            ALU_SLL, ALU_SRL, ALU_SRA: res = 1'b1;
            default:                   res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// ID-side inputs, forward sources and EX-side outputs of the ID/EX stage.
interface id_ex_stage_if;
    import mips_pkg::*;

    logic              id_valid;
    logic [DATA_W-1:0] id_rs_data, id_rt_data, id_imm;
    logic [4:0]        id_rs, id_rt, id_rd, id_shamt;
    logic [3:0]        id_alu_op;
    logic              id_alu_src, id_reg_dst;
    logic              id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
    logic              hold, flush;
    logic              exmem_reg_write, memwb_reg_write;
    logic [4:0]        exmem_rd, memwb_rd;
    logic [DATA_W-1:0] exmem_result, memwb_result;

    logic [DATA_W-1:0] alu_in1, alu_in2, ex_store_data;
    logic [3:0]        alu_op;
    logic [4:0]        alu_shamt, ex_write_reg;
    logic              ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
    logic              load_use_stall;

    modport master (
        output id_valid, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd, id_shamt,
               id_alu_op, id_alu_src, id_reg_dst, id_reg_write, id_mem_read,
               id_mem_write, id_mem_to_reg, hold, flush,
               exmem_reg_write, exmem_rd, exmem_result,
               memwb_reg_write, memwb_rd, memwb_result,
        input  alu_in1, alu_in2, alu_op, alu_shamt, ex_store_data, ex_write_reg,
               ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
               load_use_stall
    );

    modport slave (
        input  id_valid, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd, id_shamt,
               id_alu_op, id_alu_src, id_reg_dst, id_reg_write, id_mem_read,
               id_mem_write, id_mem_to_reg, hold, flush,
               exmem_reg_write, exmem_rd, exmem_result,
               memwb_reg_write, memwb_rd, memwb_result,
        output alu_in1, alu_in2, alu_op, alu_shamt, ex_store_data, ex_write_reg,
               ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
               load_use_stall
    );
endinterface

// File: rtl/ex_forward_unit.sv
// Selects the freshest value for one source register: EX/MEM beats MEM/WB
// beats the latched register-file data; $0 is never forwarded.
module ex_forward_unit
    import mips_pkg::*;
(
    input  logic [4:0]        src_reg,
    input  logic [DATA_W-1:0] reg_data,
    input  logic              exmem_reg_write,
    input  logic [4:0]        exmem_rd,
    input  logic [DATA_W-1:0] exmem_result,
    input  logic              memwb_reg_write,
    input  logic [4:0]        memwb_rd,
    input  logic [DATA_W-1:0] memwb_result,
    output logic [DATA_W-1:0] fwd_data
);

    logic [1:0] sel_s;

    // Priority select of the forwarding source.
    always_comb begin
        sel_s = FWD_REG;
        if (exmem_reg_write && (exmem_rd != 5'd0) && (exmem_rd == src_reg)) begin
            sel_s = FWD_EXMEM;
        end else if (memwb_reg_write && (memwb_rd != 5'd0) && (memwb_rd == src_reg)) begin
            sel_s = FWD_MEMWB;
        end else begin
            sel_s = FWD_REG;
        end
    end

    // Operand mux driven by the select code.
    always_comb begin
        case (sel_s)
            FWD_EXMEM: fwd_data = exmem_result;
            FWD_MEMWB: fwd_data = memwb_result;
            default:   fwd_data = reg_data;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX operand forwarding and load-use detection.
module id_ex_stage
    import mips_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    id_ex_stage_if.slave  bus
);

    ex_reg_t           ex_r;
    ex_reg_t           ex_next_s;
    logic [DATA_W-1:0] rs_cap_s, rt_cap_s;
    logic [DATA_W-1:0] fwd_rs_s, fwd_rt_s;

    // The register file is not write-before-read, so bypass MEM/WB at capture.
    always_comb begin
        rs_cap_s = bus.id_rs_data;
        rt_cap_s = bus.id_rt_data;
        if (bus.memwb_reg_write && (bus.memwb_rd != 5'd0) && (bus.memwb_rd == bus.id_rs)) begin
            rs_cap_s = bus.memwb_result;
        end else begin
            rs_cap_s = bus.id_rs_data;
        end
        if (bus.memwb_reg_write && (bus.memwb_rd != 5'd0) && (bus.memwb_rd == bus.id_rt)) begin
            rt_cap_s = bus.memwb_result;
        end else begin
            rt_cap_s = bus.id_rt_data;
        end
    end

    // Next register contents: flush beats hold beats capture.
    always_comb begin
        ex_next_s = ex_r;
        if (bus.flush) begin
            ex_next_s = EX_BUBBLE;
        end else if (bus.hold) begin
            ex_next_s = ex_r;
        end else begin
            ex_next_s.valid      = bus.id_valid;
            ex_next_s.rs         = bus.id_rs;
            ex_next_s.rt         = bus.id_rt;
            ex_next_s.rs_data    = rs_cap_s;
            ex_next_s.rt_data    = rt_cap_s;
            ex_next_s.imm        = bus.id_imm;
            ex_next_s.shamt      = bus.id_shamt;
            ex_next_s.alu_op     = bus.id_alu_op;
            ex_next_s.alu_src    = bus.id_alu_src;
            ex_next_s.write_reg  = bus.id_reg_dst ? bus.id_rd : bus.id_rt;
            ex_next_s.reg_write  = bus.id_reg_write;
            ex_next_s.mem_read   = bus.id_mem_read;
            ex_next_s.mem_write  = bus.id_mem_write;
            ex_next_s.mem_to_reg = bus.id_mem_to_reg;
        end
    end

    // ID/EX pipeline register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_r <= EX_BUBBLE;
        end else begin
            ex_r <= ex_next_s;
        end
    end

    ex_forward_unit u_fwd_rs (
        .src_reg         (ex_r.rs),
        .reg_data        (ex_r.rs_data),
        .exmem_reg_write (bus.exmem_reg_write),
        .exmem_rd        (bus.exmem_rd),
        .exmem_result    (bus.exmem_result),
        .memwb_reg_write (bus.memwb_reg_write),
        .memwb_rd        (bus.memwb_rd),
        .memwb_result    (bus.memwb_result),
        .fwd_data        (fwd_rs_s)
    );

    ex_forward_unit u_fwd_rt (
        .src_reg         (ex_r.rt),
        .reg_data        (ex_r.rt_data),
        .exmem_reg_write (bus.exmem_reg_write),
        .exmem_rd        (bus.exmem_rd),
        .exmem_result    (bus.exmem_result),
        .memwb_reg_write (bus.memwb_reg_write),
        .memwb_rd        (bus.memwb_rd),
        .memwb_result    (bus.memwb_result),
        .fwd_data        (fwd_rt_s)
    );

    assign bus.alu_in1       = is_shift_op(ex_r.alu_op) ? fwd_rt_s : fwd_rs_s;
    assign bus.alu_in2       = ex_r.alu_src ? ex_r.imm : fwd_rt_s;
    assign bus.ex_store_data = fwd_rt_s;
    assign bus.alu_op        = ex_r.alu_op;
    assign bus.alu_shamt     = ex_r.shamt;
    assign bus.ex_write_reg  = ex_r.write_reg;
    assign bus.ex_valid      = ex_r.valid;
    assign bus.ex_reg_write  = ex_r.reg_write;
    assign bus.ex_mem_read   = ex_r.mem_read;
    assign bus.ex_mem_write  = ex_r.mem_write;
    assign bus.ex_mem_to_reg = ex_r.mem_to_reg;

    // A load in EX whose target is read by the instruction in ID.
    assign bus.load_use_stall = bus.id_valid & ex_r.valid & ex_r.mem_read &
                                (ex_r.write_reg != 5'd0) &
                                ((ex_r.write_reg == bus.id_rs) | (ex_r.write_reg == bus.id_rt));

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage with hand-computed expectations.
module tb_id_ex_stage;
    import mips_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    id_ex_stage_if bus ();

    id_ex_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          input logic [31:0] rs_data, input logic [31:0] rt_data,
                          input logic [31:0] imm, input logic [4:0] shamt,
                          input logic [3:0] op, input logic src, input logic dst,
                          input logic rw, input logic mr, input logic mw, input logic m2r);
        bus.id_valid      = 1'b1;
        bus.id_rs         = rs;
        bus.id_rt         = rt;
        bus.id_rd         = rd;
        bus.id_rs_data    = rs_data;
        bus.id_rt_data    = rt_data;
        bus.id_imm        = imm;
        bus.id_shamt      = shamt;
        bus.id_alu_op     = op;
        bus.id_alu_src    = src;
        bus.id_reg_dst    = dst;
        bus.id_reg_write  = rw;
        bus.id_mem_read   = mr;
        bus.id_mem_write  = mw;
        bus.id_mem_to_reg = m2r;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        bus.id_valid = 1'b0;
        bus.id_rs_data = 32'd0; bus.id_rt_data = 32'd0; bus.id_imm = 32'd0;
        bus.id_rs = 5'd0; bus.id_rt = 5'd0; bus.id_rd = 5'd0; bus.id_shamt = 5'd0;
        bus.id_alu_op = 4'd0; bus.id_alu_src = 1'b0; bus.id_reg_dst = 1'b0;
        bus.id_reg_write = 1'b0; bus.id_mem_read = 1'b0;
        bus.id_mem_write = 1'b0; bus.id_mem_to_reg = 1'b0;
        bus.hold = 1'b0; bus.flush = 1'b0;
        bus.exmem_reg_write = 1'b0; bus.exmem_rd = 5'd0; bus.exmem_result = 32'd0;
        bus.memwb_reg_write = 1'b0; bus.memwb_rd = 5'd0; bus.memwb_result = 32'd0;

        #12;
        check("rst_valid", {31'd0, bus.ex_valid}, 32'd0);
        check("rst_in1", bus.alu_in1, 32'd0);
        check("rst_wreg", {27'd0, bus.ex_write_reg}, 32'd0);
        check("rst_stall", {31'd0, bus.load_use_stall}, 32'd0);

        // add $3,$1,$2
        rst_n = 1'b1;
        set_id(5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, 5'd0, ALU_ADD, 1'b0, 1'b1,
               1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        check("add_in1", bus.alu_in1, 32'd5);
        check("add_in2", bus.alu_in2, 32'd7);
        check("add_op", {28'd0, bus.alu_op}, 32'd0);
        check("add_wreg", {27'd0, bus.ex_write_reg}, 32'd3);
        check("add_valid", {31'd0, bus.ex_valid}, 32'd1);
        check("add_store", bus.ex_store_data, 32'd7);

        // Forwarding on the held instruction
        bus.hold = 1'b1;
        bus.exmem_reg_write = 1'b1; bus.exmem_rd = 5'd1; bus.exmem_result = 32'h10;
        bus.memwb_reg_write = 1'b1; bus.memwb_rd = 5'd1; bus.memwb_result = 32'h20;
        #1 check("fwd_exmem_wins", bus.alu_in1, 32'h10);
        bus.exmem_reg_write = 1'b0;
        #1 check("fwd_memwb", bus.alu_in1, 32'h20);
        bus.exmem_reg_write = 1'b1; bus.exmem_rd = 5'd0; bus.memwb_rd = 5'd0;
        #1 check("fwd_r0_none", bus.alu_in1, 32'd5);
        bus.memwb_rd = 5'd2;
        #1 check("fwd_rt_in2", bus.alu_in2, 32'h20);
        check("fwd_rt_store", bus.ex_store_data, 32'h20);
        bus.exmem_reg_write = 1'b0; bus.memwb_reg_write = 1'b0;
        bus.exmem_rd = 5'd0; bus.memwb_rd = 5'd0;

        // Hold across three edges with changed ID inputs
        set_id(5'd9, 5'd8, 5'd7, 32'd99, 32'd98, 32'd0, 5'd0, ALU_SUB, 1'b0, 1'b1,
               1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_in1", bus.alu_in1, 32'd5);
            check("hold_in2", bus.alu_in2, 32'd7);
            check("hold_op_wreg", {24'd0, bus.alu_op, 3'd0, bus.ex_write_reg}, {24'd0, 4'd0, 3'd0, 5'd3});
            check("hold_ctrl", {27'd0, bus.ex_valid, bus.ex_reg_write, bus.ex_mem_read,
                                bus.ex_mem_write, bus.ex_mem_to_reg}, 32'b11000);
        end
        bus.hold = 1'b0;

        // Capture-time MEM/WB bypass of rs
        set_id(5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, 5'd0, ALU_ADD, 1'b0, 1'b1,
               1'b1, 1'b0, 1'b0, 1'b0);
        bus.memwb_reg_write = 1'b1; bus.memwb_rd = 5'd1; bus.memwb_result = 32'h55;
        tick();
        bus.memwb_reg_write = 1'b0;
        #1 check("wb_bypass_in1", bus.alu_in1, 32'h55);
        check("wb_bypass_in2", bus.alu_in2, 32'd7);

        // sll $4,$2,3
        set_id(5'd0, 5'd2, 5'd4, 32'd9, 32'd1, 32'd0, 5'd3, ALU_SLL, 1'b0, 1'b1,
               1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        check("sll_in1", bus.alu_in1, 32'd1);
        check("sll_shamt", {27'd0, bus.alu_shamt}, 32'd3);
        check("sll_wreg", {27'd0, bus.ex_write_reg}, 32'd4);
        check("sll_op", {28'd0, bus.alu_op}, 32'd4);

        // addi $6,$1,-4
        set_id(5'd1, 5'd6, 5'd0, 32'd10, 32'd77, 32'hFFFF_FFFC, 5'd0, ALU_ADD, 1'b1, 1'b0,
               1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        check("addi_in1", bus.alu_in1, 32'd10);
        check("addi_in2", bus.alu_in2, 32'hFFFF_FFFC);
        check("addi_wreg", {27'd0, bus.ex_write_reg}, 32'd6);
        check("addi_store", bus.ex_store_data, 32'd77);

        // lw $5,0($1) followed by add $7,$5,$2
        set_id(5'd1, 5'd5, 5'd0, 32'd10, 32'd0, 32'd0, 5'd0, ALU_ADD, 1'b1, 1'b0,
               1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        set_id(5'd5, 5'd2, 5'd7, 32'd1, 32'd2, 32'd0, 5'd0, ALU_ADD, 1'b0, 1'b1,
               1'b1, 1'b0, 1'b0, 1'b0);
        #1 check("lu_stall_rs", {31'd0, bus.load_use_stall}, 32'd1);
        bus.id_valid = 1'b0;
        #1 check("lu_no_id_valid", {31'd0, bus.load_use_stall}, 32'd0);
        bus.id_valid = 1'b1; bus.id_rs = 5'd2; bus.id_rt = 5'd5;
        #1 check("lu_stall_rt", {31'd0, bus.load_use_stall}, 32'd1);
        bus.id_rt = 5'd3;
        #1 check("lu_no_match", {31'd0, bus.load_use_stall}, 32'd0);
        bus.id_rs = 5'd5;
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("lu_bubble_valid", {31'd0, bus.ex_valid}, 32'd0);
        check("lu_bubble_ctrl", {29'd0, bus.ex_reg_write, bus.ex_mem_write, bus.ex_mem_read}, 32'd0);
        check("lu_bubble_stall", {31'd0, bus.load_use_stall}, 32'd0);

        // sw-like instruction, then flush together with hold
        set_id(5'd1, 5'd2, 5'd0, 32'd3, 32'd4, 32'd8, 5'd0, ALU_ADD, 1'b1, 1'b0,
               1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        check("sw_mem_write", {30'd0, bus.ex_valid, bus.ex_mem_write}, 32'b11);
        bus.flush = 1'b1; bus.hold = 1'b1;
        tick();
        bus.flush = 1'b0; bus.hold = 1'b0;
        check("flush_hold_valid", {30'd0, bus.ex_valid, bus.ex_mem_write}, 32'd0);
        check("flush_hold_wreg", {27'd0, bus.ex_write_reg}, 32'd0);
        check("flush_hold_in2", bus.alu_in2, 32'd0);

        // Asynchronous reset between edges
        set_id(5'd1, 5'd2, 5'd3, 32'd11, 32'd12, 32'd0, 5'd2, ALU_SRL, 1'b0, 1'b1,
               1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        check("pre_rst_valid", {31'd0, bus.ex_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", {31'd0, bus.ex_valid}, 32'd0);
        check("async_rst_in1", bus.alu_in1, 32'd0);
        check("async_rst_op_shamt", {23'd0, bus.alu_op, bus.alu_shamt}, 32'd0);
        check("async_rst_wreg_rw", {26'd0, bus.ex_write_reg, bus.ex_reg_write}, 32'd0);
        #1 rst_n = 1'b1;
        tick();
        check("post_rst_in1", bus.alu_in1, 32'd12);
        check("post_rst_wreg", {27'd0, bus.ex_write_reg}, 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register and EX-stage operand front end for the 5-stage MIPS core. It captures decoded instruction fields from ID each cycle. It resolves EX/MEM and MEM/WB data hazards by forwarding, then drives the ALU's in1/in2/op/shamt inputs. It also detects load-use hazards and tells ID to stall.

## Interface
- DATA_W, 32, datapath width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- id_valid  in  1  ID holds a real instruction
- id_rs_data, id_rt_data  in  32  register-file read data
- id_imm  in  32  sign-extended immediate
- id_rs, id_rt, id_rd  in  5  register specifiers
- id_shamt  in  5  shift amount
- id_alu_op  in  4  ALU opcode (shared encoding)
- id_alu_src  in  1  1 = in2 takes immediate
- id_reg_dst  in  1  1 = destination rd, 0 = rt
- id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg  in  1  control bits
- hold  in  1  freeze register (downstream stall)
- flush  in  1  load bubble (branch taken / load-use)
- exmem_reg_write  in  1, exmem_rd  in  5, exmem_result  in  32  EX/MEM forward source
- memwb_reg_write  in  1, memwb_rd  in  5, memwb_result  in  32  MEM/WB forward source
- alu_in1, alu_in2  out  32  forwarded ALU operands
- alu_op  out  4, alu_shamt  out  5  registered ALU controls
- ex_store_data  out  32  forwarded rt value for sw
- ex_write_reg  out  5  selected destination register
- ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  out  1  registered controls
- load_use_stall  out  1  combinational: ID must stall and flush this stage

## Operation
- Each rising edge, the registers update by priority:
  - rst_n = 0: clear.
  - Else flush = 1: load bubble.
  - Else hold = 1: keep contents.
  - Else capture ID fields.
- Bubble and reset contents:
  - All fields 0: ex_valid, all control bits, alu_op = 0000 (add), data, and specifiers.
  - A bubble never writes a register or memory.
- Captured destination: ex_write_reg = id_reg_dst ? id_rd : id_rt.
- Capture-time WB bypass: if memwb_reg_write is set, memwb_rd is non-zero, and memwb_rd equals id_rs (or id_rt), latch memwb_result instead of the register-file data. The register file is not write-before-read.
- Forward selection for the registered rs and rt (fwd_rs / fwd_rt), combinational in EX:
  - Use EX/MEM if exmem_reg_write is set, exmem_rd is non-zero, and exmem_rd equals the specifier.
  - Else use MEM/WB under the same conditions.
  - Else use the latched data.
  - EX/MEM wins when both match. Register 0 is never forwarded.
- alu_in1:
  - fwd_rt when alu_op is 0100, 0101 or 0110 (shifts act on rt).
  - fwd_rs otherwise.
- alu_in2 = alu_src ? latched imm : fwd_rt.
- ex_store_data = fwd_rt.
- load_use_stall = ex_valid & ex_mem_read & (ex_write_reg ≠ 0) & (ex_write_reg == id_rs or ex_write_reg == id_rt), gated by id_valid.
  - The hazard unit responds by freezing PC/IF-ID and asserting flush here.

## Timing
- Latency: ID fields appear at the outputs one cycle after capture.
- Forwarding is same-cycle combinational from the exmem_* and memwb_* inputs to alu_in1/alu_in2/ex_store_data. There is no added latency.
- load_use_stall is combinational from the current registers and ID inputs. It is valid in the same cycle.
- Simultaneous events:
  - flush with hold: flush wins.
  - Reset mid-operation: outputs clear immediately, asynchronously. Capture resumes on the first edge after rst_n rises.
- During hold, forwarding muxes stay live. Operands track changes on the forward inputs.

## Structure
- Shared package mips_pkg holds:
  - ALU opcode localparams (ALU_ADD = 0000 … ALU_SLT = 1000, ALU_SLL/SRL/SRA).
  - Forward-select codes FWD_REG/FWD_EXMEM/FWD_MEMWB.
  - A shift-op decode function.
- One sub-module, ex_forward_unit: it takes the specifier and three data sources, and returns the selected value. It is instantiated twice (rs, rt).
- The pipeline register and the hazard compare live in the top.

## Test plan
- Reset release, then capture of add $3,$1,$2 (rs_data = 5, rt_data = 7) with no forwards:
  - Next cycle alu_in1 = 5, alu_in2 = 7, alu_op = 0000, ex_write_reg = 3, ex_valid = 1.
- EX/MEM and MEM/WB both target $1 (0x10 and 0x20):
  - alu_in1 = 0x10.
  - With exmem_reg_write dropped, alu_in1 = 0x20.
  - With rd = 0, no forwarding.
- sll $4,$2,3 with rt_data = 1: alu_in1 = 1, alu_shamt = 3, ex_write_reg = 4.
- Load-use: ex holds lw $5 (mem_read = 1), ID presents rs = 5:
  - load_use_stall = 1.
  - With flush asserted, the next cycle shows ex_valid = 0, reg_write = 0, mem_write = 0.
- hold with flush both asserted: bubble loaded. hold alone across 3 cycles: all registered outputs unchanged.
- Assert rst_n = 0 mid-stream between edges: all outputs are 0 before the next clock edge.
